// File: rtl/pulse_period_checker.sv
// pulse_period_checker: measures pulse intervals against period N, tracks lock, flags early/late pulses
module pulse_period_checker #(
    parameter int N        = 3,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 8,
    parameter int ECW      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pulse_in,
    input  logic           clr,
    output logic           lock,
    output logic           err_early,
    output logic           err_late,
    output logic [CW-1:0]  period,
    output logic [ECW-1:0] err_cnt
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] L_N = CW'(N);
    localparam logic [GW-1:0] L_LOCK = GW'(LOCK_CNT);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_gap, w_period_nxt;
    logic [GW-1:0]  r_good, w_good_nxt, w_good_inc;
    logic [ECW-1:0] w_err_cnt_nxt;
    logic           w_active, w_early, w_late, w_hit;
    assign w_active   = r_state != IDLE;
    assign w_early    = w_active && pulse_in && r_gap < L_N;
    assign w_late     = w_active && !pulse_in && r_gap == L_N;
    assign w_hit      = w_active && pulse_in && r_gap == L_N;
    assign w_good_inc = r_good + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gap     <= '0;
            r_good    <= '0;
            lock      <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            period    <= '0;
            err_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap     <= pulse_in ? CW'(1) : (&r_gap ? r_gap : r_gap + 1'b1);
            r_good    <= w_good_nxt;
            lock      <= w_state_nxt == LOCKED;
            err_early <= w_early;
            err_late  <= w_late;
            period    <= w_period_nxt;
            err_cnt   <= w_err_cnt_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        if (!w_active) begin
            if (pulse_in) begin
                w_state_nxt = ACQ;
                w_good_nxt  = '0;
            end
        end else if (w_hit) begin
            if (r_state == ACQ) begin
                w_good_nxt  = w_good_inc;
                w_state_nxt = w_good_inc == L_LOCK ? LOCKED : ACQ;
            end
        end else if (pulse_in || w_late) begin
            w_good_nxt  = '0;
            w_state_nxt = ACQ;
        end
    end
    always_comb begin
        w_period_nxt  = (w_active && pulse_in) ? r_gap : period;
        w_err_cnt_nxt = clr ? '0 : ((w_early || w_late) && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
    end
endmodule

// File: tb/tb_pulse_period_checker.sv
// tb_pulse_period_checker: randomized and directed stimulus against an elapsed-time reference model
module tb_pulse_period_checker;
    localparam int N  = 3;
    localparam int LC = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       clr = 1'b0;
    logic       lock_a, early_a, late_a, lock_b, early_b, late_b;
    logic [7:0] period_a, period_b, cnt_a;
    logic [1:0] cnt_b;
    int total = 0;
    int bad = 0;
    int t = 0;
    int last = 0;
    int good = 0;
    int m_period = 0;
    int m_cnt8 = 0;
    int m_cnt2 = 0;
    bit armed = 0;
    bit locked = 0;
    bit m_e = 0;
    bit m_l = 0;
    always #5 clk = ~clk;
    pulse_period_checker #(.N(N), .LOCK_CNT(LC), .CW(8), .ECW(8)) dut_a (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .clr(clr), .lock(lock_a),
        .err_early(early_a), .err_late(late_a), .period(period_a), .err_cnt(cnt_a));
    pulse_period_checker #(.N(N), .LOCK_CNT(LC), .CW(8), .ECW(2)) dut_b (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .clr(clr), .lock(lock_b),
        .err_early(early_b), .err_late(late_b), .period(period_b), .err_cnt(cnt_b));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
        end
    endtask
    // Intervals come from absolute cycle stamps, saturated like an 8-bit gap
    task automatic model(input bit p, input bit c, input bit r);
        int iv;
        t++;
        m_e = 0;
        m_l = 0;
        if (r) begin
            armed = 0; locked = 0; good = 0; m_period = 0; m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        if (!armed) begin
            if (p) begin
                armed = 1; good = 0; last = t;
            end
        end else begin
            iv = (t - last > 255) ? 255 : t - last;
            if (p) begin
                m_period = iv;
                last = t;
                if (iv == N) begin
                    if (!locked) begin
                        good++;
                        if (good == LC) locked = 1;
                    end
                end else begin
                    m_e = iv < N;
                    good = 0;
                    locked = 0;
                end
            end else if (iv == N) begin
                m_l = 1; good = 0; locked = 0;
            end
        end
        if (c) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (m_e || m_l) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask
    task automatic step(input bit p, input bit c = 0, input bit r = 0);
        pulse_in = p;
        clr = c;
        rst = r;
        @(posedge clk);
        model(p, c, r);
        #1;
        check("lock_a", lock_a, locked);
        check("early_a", early_a, m_e);
        check("late_a", late_a, m_l);
        check("period_a", period_a, m_period);
        check("cnt_a", cnt_a, m_cnt8);
        check("lock_b", lock_b, locked);
        check("early_b", early_b, m_e);
        check("late_b", late_b, m_l);
        check("period_b", period_b, m_period);
        check("cnt_b", cnt_b, m_cnt2);
    endtask
    task automatic gap_pulse(input int k, input int n = 1);
        for (int j = 0; j < n; j++) begin
            for (int i = 1; i < k; i++) step(0);
            step(1);
        end
    endtask
    initial begin
        step(0, 0, 1);
        step(0, 0, 1);
        gap_pulse(3, 6);
        gap_pulse(2);
        gap_pulse(3, 5);
        gap_pulse(6);
        gap_pulse(3, 5);
        for (int i = 0; i < 5; i++) step(1);
        gap_pulse(3, 6);
        step(0, 0, 1);
        gap_pulse(2);
        gap_pulse(3, 2);
        for (int i = 0; i < 5; i++) step(1);
        step(1, 1);
        step(0);
        gap_pulse(300);
        gap_pulse(3, 6);
        repeat (600) begin
            int k, sel;
            sel = int'($urandom_range(0, 9));
            k = sel < 5 ? N : sel < 7 ? int'($urandom_range(1, N - 1)) : int'($urandom_range(N + 1, 8));
            for (int i = 1; i < k; i++) step(0, $urandom_range(0, 39) == 0);
            step(1, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
